uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle core's data bus, parallel to the data memory. It decodes the core's store and load traffic (address, write data, byte enables, write strobe) for its own register window. Bytes written to TXDATA go into a small FIFO and are serialised 8N1 on `tx`. The top level uses `sel` to steer the load-data mux between data memory and this block.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0100: word-aligned base of the 3-word register window.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of 2, range 2..8.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `we`  in  1: store strobe from the core.
- `a`  in  32: data address from the core.
- `wd`  in  32: store data.
- `be`  in  4: byte enables; `be[0]` qualifies lane 0.
- `sel`  out  1: combinational; 1 when `a[31:4]==BASE_ADDR[31:4]` and `a[3:2]` ≤ 2.
- `rd`  out  32: combinational read data for the addressed register; 0 when `sel`=0.
- `tx`  out  1: serial line, registered, idle high.

## Operation
Register map (offset from `BASE_ADDR`):
- 0x0 TXDATA:
  - Write with `we & sel & be[0]` pushes `wd[7:0]`.
  - Reads return 0.
- 0x4 STATUS (read-only except bit 3):
  - bit0 busy (FSM ≠ IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[7:4] FIFO count; rest 0.
  - Writing with `be[0]` and `wd[3]`=1 clears overflow (W1C).
- 0x8 DIVCNT:
  - Reads return `CLKS_PER_BIT` (constant); writes are ignored.

FIFO:
- A push when full (count evaluated before the edge) is dropped and sets overflow.
- This holds even if the FSM pops on the same edge.
- A push and pop on the same edge when not full: count unchanged.

TX FSM states IDLE, START, DATA, STOP; a bit counter (3 bits) and a baud counter (0..`CLKS_PER_BIT`-1):
- IDLE: if FIFO non-empty, pop into shift register and go to START; baud counter cleared.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: shift out LSB first, 8 bits, each `CLKS_PER_BIT` cycles, then STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
  - At the end of STOP, if FIFO non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.

Reset values:
- `tx`=1; FSM IDLE; FIFO empty (count 0, pointers 0); overflow 0.
- Combinational `rd`/`sel` follow `a`.

Reset mid-frame:
- `tx` returns high asynchronously.
- Queued bytes are discarded.
- No partial frame resumes.

## Timing
- Store at edge N to an empty FIFO with FSM IDLE:
  - empty=0 after N.
  - Pop and START entry at N+1.
  - `tx` falls after N+1.
- Frame length exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no extra idle cycle.
- busy deasserts on the edge that ends STOP when the FIFO is empty.
- `rd` is combinational, same cycle as `a`, which matches the core's single-cycle load path. Status reflects register state before the current edge.
- Pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into bits[7:4].

## Structure
- Package `mmio_pkg`:
  - register offsets (TXDATA/STATUS/DIVCNT);
  - STATUS bit indices;
  - TX state encoding (2-bit localparams IDLE=0, START=1, DATA=2, STOP=3).
- One sub-module `sync_fifo` (parameters WIDTH=8, DEPTH):
  - ports `clk`, `reset`, push, pop, din, dout, full, empty, count.
  - First-word-fall-through.
- Top-level FSM, baud/bit counters, address decode and read mux live in `uart_tx_mmio`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Single byte: store 0x55 to 0x100 with be=4'b0001. Required response:
  - `tx` low 4 cycles starting one edge after the store;
  - then bits 1,0,1,0,1,0,1,0 at 4 cycles each;
  - then high 4 cycles;
  - STATUS reads busy=1 during the frame and 0x04 (empty) after.
- Back-to-back: store 0xA0, 0x0F on consecutive cycles. Required response:
  - two frames totalling 80 cycles, with STOP of frame 1 immediately followed by START of frame 2;
  - count reads 1 while frame 1 is sent.
- Overflow: 6 stores while FSM busy. Required response:
  - first pop plus 4 queued accepted; 6th dropped;
  - STATUS=0x4B (count 4, overflow, full, busy);
  - write 0x8 to 0x104 clears bit3.
- Byte enables and decode:
  - store with be=4'b0010 to 0x100 leaves the FIFO unchanged;
  - address 0x10C gives `sel`=0, `rd`=0;
  - read 0x108 returns 4.
- Reset mid-frame: assert `reset` during DATA with 2 bytes queued. Required response:
  - `tx`=1 immediately; STATUS=0x04 after release;
  - no further frames.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and TX state encoding.
package mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIVCNT = 4'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE  = 2'd0;
  localparam tx_state_t START = 2'd1;
  localparam tx_state_t DATA  = 2'd2;
  localparam tx_state_t STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is
// dropped even when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter on the core data bus: TXDATA / STATUS / DIVCNT
// register window, TX FIFO and serialising FSM.
module uart_tx_mmio
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic        sel,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    off;
  logic          wr_tx;
  logic          wr_clr;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel    = (a[31:4] == BASE_ADDR[31:4]) && (a[3:2] != 2'b11);
  assign off    = {a[3:2], 2'b00};
  assign wr_tx  = we & sel & be[0] & (off == OFF_TXDATA);
  assign wr_clr = we & sel & be[0] & (off == OFF_STATUS) & wd[3];
  assign tx     = tx_q;

  assign unused_bits = ^{a[1:0], wd[31:8], be[3:1]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Overflow is judged on the pre-edge full flag, same as the FIFO
  always_comb begin
    ovf_d = ovf_q;
    if (wr_tx & fifo_full) ovf_d = 1'b1;
    else if (wr_clr)       ovf_d = 1'b0;
  end

  always_comb begin
    status                    = '0;
    status[ST_BUSY]           = state_q != IDLE;
    status[ST_FULL]           = fifo_full;
    status[ST_EMPTY]          = fifo_empty;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT_LSB +: 4]   = 4'(fifo_cnt);
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (off)
        OFF_STATUS: rd = status;
        OFF_DIVCNT: rd = 32'(CLKS_PER_BIT);
        default:    rd = '0;
      endcase
    end
  end

  assign baud_last = baud_q == BAUD_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame when data is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  // tx is registered from the next state so it changes with the FSM
  always_comb begin
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

endmodule
